// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by fetch, decode and hazard detection.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mips_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // sll $0,$0,0 encodes as all zeros; used for bubbles and reset.
    localparam logic [XLEN-1:0] NOP_INSTR_WORD = 32'h0000_0000;

    // Register-specifier field positions within an R/I-type instruction.
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    // Instruction fetch is word-granular; drop the byte offset.
    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with hold, redirect and sequential (PC+4) next-address selection.
// Latency: next PC takes effect on the rising clk edge; pcPlus4 is combinational.
// Backpressure: writeEn=0 holds the PC and masks any redirect in that cycle.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   writeEn         1 = PC may advance this cycle
//   redirectValid   1 = load redirectTarget (word-aligned) instead of PC+4
//   redirectTarget  branch/jump destination from ID
//   pc              current fetch PC
//   pcPlus4         pc + 4, wraps modulo 2^32
module pc_register
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            writeEn,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectTarget,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4
);

    logic [XLEN-1:0] nextPc;

    assign pcPlus4 = pc + XLEN'(4);

    always_comb begin
        nextPc = pcPlus4;
        if (redirectValid) begin
            nextPc = alignWord(redirectTarget);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (writeEn) begin
            pc <= nextPc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, instruction-memory address, IF/ID pipeline register, stall counter.
// Latency: word fetched at PC in cycle N appears on ifid_* in cycle N+1; a redirect costs one bubble.
// Backpressure: pc_write=0 holds PC, ifid_write=0 holds IF/ID; redirect ignored by whichever is held.
//
// Ports:
//   clk, rst                         rising-edge clock, asynchronous active-high reset
//   pc_write, ifid_write             stall controls from hazard detection
//   redirect_valid, redirect_target  taken branch / jump from ID
//   imem_addr, imem_rdata            combinational instruction memory interface
//   pc                               current fetch PC
//   ifid_instr, ifid_pc_plus4        IF/ID pipeline register contents
//   ifid_valid                       0 = IF/ID holds a bubble
//   ifid_rs, ifid_rt                 register fields of ifid_instr for hazard detection
//   stall_count                      saturating count of cycles with pc_write=0
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD,
    parameter int              CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_write,
    input  logic                  ifid_write,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_target,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [XLEN-1:0]       imem_rdata,
    output logic [XLEN-1:0]       pc,
    output logic [XLEN-1:0]       ifid_instr,
    output logic [XLEN-1:0]       ifid_pc_plus4,
    output logic                  ifid_valid,
    output logic [REG_ADDR_W-1:0] ifid_rs,
    output logic [REG_ADDR_W-1:0] ifid_rt,
    output logic [CNT_W-1:0]      stall_count
);

    logic [XLEN-1:0] pcPlus4;

    pc_register #(
        .RESET_PC(RESET_PC)
    ) pcReg (
        .clk            (clk),
        .rst            (rst),
        .writeEn        (pc_write),
        .redirectValid  (redirect_valid),
        .redirectTarget (redirect_target),
        .pc             (pc),
        .pcPlus4        (pcPlus4)
    );

    assign imem_addr = pc;

    // IF/ID register. A redirect flushes the word fetched down the
    // wrong path; pc_plus4 is still captured so a bubble shows where it came from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else if (ifid_write) begin
            ifid_pc_plus4 <= pcPlus4;
            if (redirect_valid) begin
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else begin
                ifid_instr <= imem_rdata;
                ifid_valid <= 1'b1;
            end
        end
    end

    // Pure slices of the registered word, no added latency.
    assign ifid_rs = ifid_instr[RS_MSB:RS_LSB];
    assign ifid_rt = ifid_instr[RT_MSB:RT_LSB];

    // Performance counter: sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        ifid_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_rdata;

    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic [15:0] stall_count;

    // Second instance with a 2-bit counter to exercise saturation.
    logic [31:0] satImemAddr;
    logic [31:0] satPc;
    logic [31:0] satIfidInstr;
    logic [31:0] satIfidPcPlus4;
    logic        satIfidValid;
    logic [4:0]  satIfidRs;
    logic [4:0]  satIfidRt;
    logic [1:0]  satStallCount;

    int nChecks = 0;
    int nFail   = 0;

    localparam logic [31:0] LW_WORD  = 32'h8C01_0004; // lw $1,4($0): rs=0 rt=1
    localparam logic [31:0] ADD_WORD = 32'h0043_2020; // add $4,$2,$3: rs=2 rt=3

    // Instruction memory model: one distinct word at 0x100, LW_WORD elsewhere.
    always_comb begin
        imem_rdata = LW_WORD;
        if (imem_addr == 32'h0000_0100) begin
            imem_rdata = ADD_WORD;
        end
    end

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc              (pc),
        .ifid_instr      (ifid_instr),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_valid      (ifid_valid),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .stall_count     (stall_count)
    );

    fetch_stage #(.CNT_W(2)) dutSat (
        .clk             (clk),
        .rst             (rst),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (satImemAddr),
        .imem_rdata      (imem_rdata),
        .pc              (satPc),
        .ifid_instr      (satIfidInstr),
        .ifid_pc_plus4   (satIfidPcPlus4),
        .ifid_valid      (satIfidValid),
        .ifid_rs         (satIfidRs),
        .ifid_rt         (satIfidRt),
        .stall_count     (satStallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full IF/ID snapshot of the default instance.
    task automatic chkIfid(input string tag, input logic [31:0] expInstr,
                           input logic [31:0] expPc4, input logic expValid);
        chk({tag, ".instr"}, ifid_instr, expInstr);
        chk({tag, ".pc4"},   ifid_pc_plus4, expPc4);
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(expValid));
        chk({tag, ".rs"},    32'(ifid_rs), 32'(expInstr[25:21]));
        chk({tag, ".rt"},    32'(ifid_rt), 32'(expInstr[20:16]));
    endtask

    task automatic chkReset(input string tag);
        chk({tag, ".pc"},    pc, 32'h0);
        chk({tag, ".iaddr"}, imem_addr, 32'h0);
        chkIfid(tag, 32'h0, 32'h0, 1'b0);
        chk({tag, ".cnt"},   32'(stall_count), 32'h0);
        chk({tag, ".satcnt"}, 32'(satStallCount), 32'h0);
    endtask

    initial begin
        rst             = 1'b1;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // Reset state before any clock edge.
        #3;
        chkReset("reset");
        rst = 1'b0;

        // Free run: pc 4, 8 after edges 1, 2.
        tick();
        chk("run1.pc", pc, 32'h4);
        chkIfid("run1", LW_WORD, 32'h4, 1'b1);
        tick();
        chk("run2.pc", pc, 32'h8);
        chk("run2.iaddr", imem_addr, 32'h8);
        chk("run2.pc4", ifid_pc_plus4, 32'h8);

        // Load-use stall for two cycles at pc=8.
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        tick();
        tick();
        chk("stall.pc", pc, 32'h8);
        chkIfid("stall", LW_WORD, 32'h8, 1'b1);
        chk("stall.cnt", 32'(stall_count), 32'd2);
        chk("stall.satcnt", 32'(satStallCount), 32'd2);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        tick();
        chk("release.pc", pc, 32'hC);
        chk("release.pc4", ifid_pc_plus4, 32'hC);
        tick();
        chk("run6.pc", pc, 32'h10);

        // Redirect with unaligned target: low bits dropped, one bubble.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0103;
        tick();
        chk("redir.pc", pc, 32'h100);
        chkIfid("redir", 32'h0, 32'h14, 1'b0);
        redirect_valid = 1'b0;
        tick();
        chk("redir2.pc", pc, 32'h104);
        chkIfid("redir2", ADD_WORD, 32'h104, 1'b1);

        // Redirect while stalled is ignored.
        pc_write        = 1'b0;
        ifid_write      = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        tick();
        chk("stredir.pc", pc, 32'h104);
        chkIfid("stredir", ADD_WORD, 32'h104, 1'b1);
        chk("stredir.cnt", 32'(stall_count), 32'd3);
        chk("stredir.satcnt", 32'(satStallCount), 32'd3);
        // Release with redirect still pending.
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        tick();
        chk("stredir2.pc", pc, 32'h200);
        chkIfid("stredir2", 32'h0, 32'h108, 1'b0);
        redirect_valid = 1'b0;
        tick();
        chk("stredir3.pc", pc, 32'h204);
        chkIfid("stredir3", LW_WORD, 32'h204, 1'b1);

        // Wrap: steer pc to the top word, then free-run past 2^32.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        chk("wrap.pc", pc, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        chk("wrap2.pc", pc, 32'h0);
        chk("wrap2.iaddr", imem_addr, 32'h0);
        chkIfid("wrap2", LW_WORD, 32'h0, 1'b1);

        // Five stall cycles: 16-bit counter reaches 8, 2-bit counter stays at 3.
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("sat.pc", pc, 32'h0);
        chk("sat.cnt", 32'(stall_count), 32'd8);
        chk("sat.satcnt", 32'(satStallCount), 32'd3);
        chk("sat.satpc", satPc, 32'h0);

        // pc_write=1, ifid_write=0: PC advances, IF/ID holds.
        pc_write = 1'b1;
        tick();
        chk("pconly.pc", pc, 32'h4);
        chkIfid("pconly", LW_WORD, 32'h0, 1'b1);
        // pc_write=0, ifid_write=1: re-capture at the held PC.
        pc_write   = 1'b0;
        ifid_write = 1'b1;
        tick();
        chk("ifidonly.pc", pc, 32'h4);
        chkIfid("ifidonly", LW_WORD, 32'h8, 1'b1);
        chk("ifidonly.cnt", 32'(stall_count), 32'd9);

        // Asynchronous reset mid-stall, between edges.
        ifid_write = 1'b0;
        #4;
        rst = 1'b1;
        #1;
        chkReset("areset");
        chk("areset.satpc", satPc, 32'h0);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        chk("post.pc", pc, 32'h4);
        chkIfid("post", LW_WORD, 32'h4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
